// File: rtl/fft_channel_arbiter.sv
// fft_channel_arbiter: round-robin owner selection for the shared FFT datapath with frame watchdog
module fft_channel_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int FFT_POINTS     = 8192,
    parameter int LEVEL_W        = 14,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fft_enable,
    input  logic [NUM_CH-1:0]         ch_mask,
    input  logic [NUM_CH*LEVEL_W-1:0] ch_level,
    input  logic                      frame_done,
    input  logic                      err_clr,
    output logic [NUM_CH-1:0]         grant,
    output logic [CH_W-1:0]           grant_id,
    output logic                      frame_start,
    output logic                      frame_abort,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [15:0]               done_count
);
    localparam int WD_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, ARB, START, RUN, GAP} state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   elig, grant_q, grant_d;
    logic [CH_W-1:0]     rr_q, rr_d, id_q, id_d, win, nxt;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                start_q, start_d, abort_q, abort_d, err_q, err_d;
    logic                found, expired;
    int                  idx;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_elig
        assign elig[g] = ch_mask[g] && (ch_level[g*LEVEL_W +: LEVEL_W] >= LEVEL_W'(FFT_POINTS));
    end

    // descending scan so the channel closest to rr_q is the last (winning) assignment
    always_comb begin
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = (int'(rr_q) + k) % NUM_CH;
            if (elig[idx]) begin
                win   = CH_W'(idx);
                found = 1'b1;
            end
        end
    end

    assign nxt     = (id_q == CH_W'(NUM_CH - 1)) ? '0 : id_q + CH_W'(1);
    assign expired = wd_q == WD_W'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        rr_d    = rr_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        err_d   = err_q & ~err_clr;
        case (state_q)
            IDLE: if (fft_enable && found) begin
                state_d = ARB;
                grant_d = NUM_CH'(1) << win;
                id_d    = win;
            end
            ARB: begin
                state_d = START;
                start_d = 1'b1;
            end
            START: begin
                state_d = RUN;
                wd_d    = '0;
            end
            RUN: begin
                wd_d = wd_q + WD_W'(1);
                if (frame_done || expired) begin
                    state_d = GAP;
                    grant_d = '0;
                    rr_d    = nxt;
                    gap_d   = '0;
                    cnt_d   = cnt_q + 16'(frame_done);
                    abort_d = ~frame_done;
                    err_d   = (err_q & ~err_clr) | ~frame_done;
                end
            end
            GAP: begin
                gap_d   = gap_q + GAP_W'(1);
                state_d = (gap_q == GAP_W'(GAP_CYCLES - 1)) ? IDLE : GAP;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            rr_q    <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            cnt_q   <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            rr_q    <= rr_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            abort_q <= abort_d;
            err_q   <= err_d;
        end
    end

    assign grant       = grant_q;
    assign grant_id    = id_q;
    assign frame_start = start_q;
    assign frame_abort = abort_q;
    assign busy        = state_q != IDLE;
    assign timeout_err = err_q;
    assign done_count  = cnt_q;
endmodule

// File: tb/tb_fft_channel_arbiter.sv
// tb_fft_channel_arbiter: directed corner scenarios plus random traffic against an ownership/timeline model
module tb_fft_channel_arbiter;
    localparam int N = 4, LW = 14, TO = 100, GAP = 2, FP = 16;

    logic clk = 0, rst = 1, fft_enable = 0, frame_done = 0, err_clr = 0;
    logic [N-1:0] ch_mask = '0;
    logic [N*LW-1:0] ch_level = '0;
    logic [N-1:0] grant;
    logic [1:0] grant_id;
    logic frame_start, frame_abort, busy, timeout_err;
    logic [15:0] done_count;

    fft_channel_arbiter #(.NUM_CH(N), .CH_W(2), .FFT_POINTS(FP), .LEVEL_W(LW),
                          .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .rst(rst), .fft_enable(fft_enable), .ch_mask(ch_mask), .ch_level(ch_level),
        .frame_done(frame_done), .err_clr(err_clr), .grant(grant), .grant_id(grant_id),
        .frame_start(frame_start), .frame_abort(frame_abort), .busy(busy),
        .timeout_err(timeout_err), .done_count(done_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc_n = 0;
    // model: current owner (-1 none), cycles since grant became visible, remaining gap cycles
    int m_own = -1, m_t = 0, m_gap = 0, m_ptr = 0, m_id = 0;
    logic m_abort = 0, m_err = 0;
    logic [15:0] m_cnt = '0;
    int done_lat = -1;
    logic stray = 0;
    int fs_cyc = -1, ab_cyc = -1;
    int ids[$];

    function automatic int lvl(int c);
        return int'(ch_level[c*LW +: LW]);
    endfunction

    task automatic set_level(int c, int v);
        ch_level[c*LW +: LW] = LW'(v);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_t = 0; m_gap = 0; m_ptr = 0; m_id = 0;
        m_abort = 0; m_err = 0; m_cnt = '0;
    endtask

    task automatic model_step();
        bit fin = 0, to = 0;
        m_abort = 0;
        if (err_clr) m_err = 0;
        if (m_own >= 0) begin
            if (m_t >= 2 && frame_done) begin
                m_cnt++;
                fin = 1;
            end else if (m_t - 2 == TO - 1) begin
                to = 1;
                fin = 1;
            end
            if (fin) begin
                m_abort = to;
                if (to) m_err = 1;
                m_ptr = (m_own + 1) % N;
                m_own = -1;
                m_gap = GAP;
            end else m_t++;
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (fft_enable) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (ch_mask[c] && lvl(c) >= FP) begin
                    m_own = c; m_id = c; m_t = 0;
                    break;
                end
            end
        end
    endtask

    task automatic compare();
        if (frame_start) begin fs_cyc = cyc_n; ids.push_back(int'(grant_id)); end
        if (frame_abort) ab_cyc = cyc_n;
        chk("grant", 32'(grant), m_own >= 0 ? (1 << m_own) : 0);
        chk("grant_id", 32'(grant_id), m_id);
        chk("frame_start", 32'(frame_start), 32'(m_own >= 0 && m_t == 1));
        chk("frame_abort", 32'(frame_abort), 32'(m_abort));
        chk("busy", 32'(busy), 32'(m_own >= 0 || m_gap > 0));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("done_count", 32'(done_count), 32'(m_cnt));
    endtask

    task automatic cyc();
        frame_done = stray || (m_own >= 0 && done_lat >= 0 && m_t == 1 + done_lat);
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc_n++;
        compare();
        stray = 0;
    endtask

    task automatic all_levels(int v);
        for (int c = 0; c < N; c++) set_level(c, v);
    endtask

    task automatic do_reset();
        rst = 1;
        @(negedge clk);
        rst = 0;
        model_reset();
        fs_cyc = -1; ab_cyc = -1;
        ids.delete();
    endtask

    initial begin
        int n, cnt0;
        int exp_seq[5] = '{0, 1, 2, 3, 0};
        logic bad;
        repeat (2) @(negedge clk);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_count", 32'(done_count), 0);
        chk("rst_id", 32'(grant_id), 0);
        rst = 0;
        model_reset();

        // single requester
        ch_mask = 4'hF; set_level(2, 16); fft_enable = 1; done_lat = 5;
        cyc();
        chk("s1_grant", 32'(grant), 32'h4);
        cyc();
        chk("s1_start", 32'(frame_start), 1);
        repeat (6) cyc();
        chk("s1_count", 32'(done_count), 1);
        chk("s1_grant_off", 32'(grant), 0);
        set_level(2, 0);
        cyc(); cyc();
        chk("s1_idle", 32'(busy), 0);

        // fairness
        do_reset();
        all_levels(20); done_lat = 10;
        n = 0;
        while (done_count != 16'd5 && n < 200) begin cyc(); n++; end
        fft_enable = 0;
        repeat (4) cyc();
        chk("fair_frames", ids.size(), 5);
        for (int i = 0; i < 5; i++) if (i < ids.size()) chk("fair_id", ids[i], exp_seq[i]);
        chk("fair_count", 32'(done_count), 5);

        // mask and threshold
        do_reset();
        set_level(0, 15); set_level(1, 16); set_level(2, 0); set_level(3, 16);
        ch_mask = 4'b1101; fft_enable = 1; done_lat = 3;
        bad = 0;
        repeat (60) begin cyc(); if (grant[0] || grant[1]) bad = 1; end
        chk("mask_no_ch01", 32'(bad), 0);
        chk("mask_frames", 32'(ids.size() >= 3), 1);
        for (int i = 0; i < ids.size(); i++) chk("mask_id", ids[i], 3);

        // watchdog
        do_reset();
        ch_mask = 4'hF; all_levels(20); done_lat = -1;
        n = 0;
        while (ab_cyc < 0 && n < 300) begin cyc(); n++; end
        chk("wd_latency", ab_cyc - (fs_cyc + 1), 100);
        chk("wd_err", 32'(timeout_err), 1);
        chk("wd_count", 32'(done_count), 0);
        done_lat = 4;
        n = 0;
        while (ids.size() < 2 && n < 50) begin cyc(); n++; end
        chk("wd_next_n", ids.size(), 2);
        if (ids.size() == 2) chk("wd_next_id", ids[1], 1);
        err_clr = 1; cyc(); err_clr = 0;
        chk("err_clr", 32'(timeout_err), 0);

        // done in the timeout cycle
        do_reset();
        done_lat = TO; ab_cyc = -1;
        n = 0;
        while (done_count != 16'd1 && n < 300) begin cyc(); n++; end
        cyc();
        chk("coll_abort", ab_cyc, -1);
        chk("coll_err", 32'(timeout_err), 0);
        chk("coll_count", 32'(done_count), 1);

        // frame_done while idle
        fft_enable = 0;
        repeat (6) cyc();
        cnt0 = int'(done_count);
        stray = 1; cyc(); cyc();
        chk("idle_done", 32'(done_count), cnt0);

        // enable dropped mid-frame
        fft_enable = 1; done_lat = 6; ids.delete();
        n = 0;
        while (ids.size() == 0 && n < 20) begin cyc(); n++; end
        fft_enable = 0;
        repeat (25) cyc();
        chk("en_drop_count", 32'(done_count), cnt0 + 1);
        chk("en_drop_idle", 32'(busy), 0);
        chk("en_drop_grant", 32'(grant), 0);

        // asynchronous reset mid-RUN
        fft_enable = 1; done_lat = -1; ids.delete();
        n = 0;
        while (ids.size() == 0 && n < 20) begin cyc(); n++; end
        repeat (3) cyc();
        #2 rst = 1;
        #1;
        chk("arst_grant", 32'(grant), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_count", 32'(done_count), 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        ids.delete(); done_lat = 3;
        n = 0;
        while (ids.size() == 0 && n < 20) begin cyc(); n++; end
        chk("arst_restart_n", ids.size(), 1);
        if (ids.size() > 0) chk("arst_restart_id", ids[0], 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 8 == 0) begin
                for (int c = 0; c < N; c++) set_level(c, int'($urandom_range(0, 31)));
                ch_mask = N'($urandom_range(0, 15));
                fft_enable = ($urandom_range(0, 9) != 0);
            end
            if (m_own < 0) begin
                n = int'($urandom_range(0, 9));
                done_lat = (n == 0) ? 120 : (n == 1) ? TO : int'($urandom_range(0, 20));
            end
            err_clr = ($urandom_range(0, 15) == 0);
            stray = ($urandom_range(0, 19) == 0);
            cyc();
        end
        err_clr = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_channel_arbiter.md
Name: fft_channel_arbiter

Overview:
- Round-robin scheduler that shares the single FFT datapath controller among NUM_CH sample-FIFO channels.
- It watches each channel's FIFO read water level and picks an eligible channel. It grants that channel exclusively, pulses a frame start, then waits for frame completion. A watchdog aborts hung frames.
- It sits between the per-channel FIFOs and the FFT sequencing/windowing controller. Its grant one-hot drives the FIFO read-enable and spectrum-output muxing.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, width of grant_id; equals ceil(log2(NUM_CH)), minimum 1
FFT_POINTS, 8192, samples per frame; a channel is eligible when its level >= FFT_POINTS
LEVEL_W, 14, width of each FIFO water-level field
TIMEOUT_CYCLES, 65535, maximum cycles in RUN before abort
GAP_CYCLES, 2, idle cycles between frames; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
fft_enable  in  1  global enable; new grants are issued only while high
ch_mask  in  NUM_CH  per-channel enable; bit i = 0 makes channel i never eligible
ch_level  in  NUM_CH*LEVEL_W  packed FIFO read water levels; channel i occupies [i*LEVEL_W +: LEVEL_W]
frame_done  in  1  one-cycle pulse from the FFT path when the last output sample is accepted
err_clr  in  1  clears timeout_err
grant  out  NUM_CH  one-hot grant to the owning channel; all zero when no channel owns the FFT
grant_id  out  CH_W  binary index of the granted channel; holds its last value when idle
frame_start  out  1  one-cycle pulse that starts a frame on the FFT controller
frame_abort  out  1  one-cycle pulse on watchdog expiry; the FFT controller must flush
busy  out  1  high from ARB through GAP
timeout_err  out  1  sticky watchdog error flag
done_count  out  16  number of completed frames; wraps modulo 2^16

Behaviour:
- Reset (asynchronous on rst=1):
  - State goes to IDLE.
  - grant = 0, grant_id = 0, frame_start = 0, frame_abort = 0, busy = 0, timeout_err = 0, done_count = 0.
  - Round-robin pointer rr_ptr = 0; watchdog and gap counters = 0.
- Reset mid-frame drops the grant immediately. No abort pulse is issued.
- Eligibility vector: elig[i] = ch_mask[i] & (ch_level[i] >= FFT_POINTS). It is evaluated combinationally in IDLE only.
- IDLE: if fft_enable and |elig, register the winner and go to ARB.
  - Winner = first set elig bit searching rr_ptr, rr_ptr+1, ... modulo NUM_CH.
  - Otherwise stay in IDLE.
- ARB (1 cycle):
  - Drive grant[winner] = 1 and grant_id = winner (registered outputs).
  - Go to START.
- START (1 cycle):
  - frame_start = 1; clear the watchdog.
  - Go to RUN.
- RUN:
  - The grant is held and the watchdog increments every cycle.
  - If frame_done: done_count += 1, rr_ptr = winner+1 (mod NUM_CH), go to GAP.
  - Else if watchdog == TIMEOUT_CYCLES-1: pulse frame_abort for 1 cycle, set timeout_err, rr_ptr = winner+1, go to GAP.
  - If frame_done and timeout fall in the same cycle, done wins: no abort and no error.
- GAP:
  - grant = 0 on GAP entry, so the grant deasserts on the first GAP cycle.
  - Count GAP_CYCLES cycles, then go to IDLE.
- Timing from IDLE decision to frame_start: 2 cycles.
  - Cycle N: IDLE with an eligible channel.
  - Cycle N+1: grant valid.
  - Cycle N+2: frame_start high.
- fft_enable falling during ARB/START/RUN does not cancel the frame; it completes normally. Only new grants are inhibited.
- ch_mask or ch_level changes after IDLE do not affect the current owner.
- frame_done outside RUN is ignored; done_count does not change.
- err_clr clears timeout_err; if err_clr and a timeout fall in the same cycle, set wins.
- grant is always one-hot or zero and never changes between ARB and GAP entry.
- done_count wraps from 16'hFFFF to 16'h0000.

Test Plan:
- Bench parameters for all scenarios: NUM_CH=4, FFT_POINTS=16, TIMEOUT_CYCLES=100, GAP_CYCLES=2.
- Single requester: ch_level[2]=16, mask=4'hF, fft_enable=1 -> grant=4'b0100 one cycle after the IDLE decision; frame_start 1 cycle later; after frame_done, done_count=1, grant=0, and back in IDLE after 2 gap cycles.
- Fairness: all four levels=20 held constant, frame_done 10 cycles after each frame_start -> grant_id sequence 0,1,2,3,0; done_count=5.
- Mask/threshold: ch_level[0]=15, ch_level[1]=16 with mask=4'b1101, ch_level[3]=16 -> channel 3 granted, never channel 0 or 1.
- Watchdog: grant channel 0 and withhold frame_done -> frame_abort pulses exactly 100 cycles after the first RUN cycle; timeout_err=1; done_count unchanged; next grant goes to channel 1 if eligible. Assert err_clr -> timeout_err=0.
- Corner collisions:
  - frame_done in the same cycle as the timeout -> no abort, timeout_err stays 0, done_count increments.
  - frame_done pulsed in IDLE -> ignored.
  - fft_enable dropped during RUN -> frame completes and no new grant is issued.
- Reset mid-RUN: assert rst -> grant=0, busy=0, done_count=0 immediately (asynchronous, before the next clk edge); after release, arbitration restarts from channel 0.
